// File: rtl/dpmem_pkg.sv
// dpmem_pkg: collision policy constants, clear FSM state type and lane-count helper shared by dpmem_fwd and dpmem_core
package dpmem_pkg;
  localparam int COLLISION_WRITE_FIRST = 0;
  localparam int COLLISION_READ_FIRST = 1;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic int lanes(input int width, input int lane);
    return width / lane;
  endfunction
endpackage

// File: rtl/dpmem_core.sv
// dpmem_core: inferred simple dual-port array with per-lane writes and one registered read-first output
module dpmem_core
  import dpmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE = 8,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [lanes(WIDTH, LANE)-1:0] write_enable,
  input  logic [DEPTH_LOG2-1:0]         write_address,
  input  logic [WIDTH-1:0]              write_data,
  input  logic                          read_enable,
  input  logic [DEPTH_LOG2-1:0]         read_address,
  output logic [WIDTH-1:0]              read_data
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clock)
    for (int i = 0; i < lanes(WIDTH, LANE); i++)
      if (write_enable[i]) mem[write_address][i*LANE +: LANE] <= write_data[i*LANE +: LANE];
  always_ff @(posedge clock)
    if (!reset_n) read_data <= '0;
    else if (read_enable) read_data <= mem[read_address];
endmodule

// File: rtl/dpmem_fwd.sv
// dpmem_fwd: parametrised dual-port RAM with byte-lane writes, configurable read latency, defined collision policy and post-reset clear sweep
module dpmem_fwd
  import dpmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE = 8,
  parameter int DEPTH_LOG2 = 14,
  parameter int READ_LATENCY = 2,
  parameter int COLLISION = COLLISION_WRITE_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [lanes(WIDTH, LANE)-1:0] write_enable,
  input  logic [DEPTH_LOG2-1:0]         write_address,
  input  logic [WIDTH-1:0]              write_data,
  input  logic                          read_valid,
  input  logic [DEPTH_LOG2-1:0]         read_address,
  output logic                          read_data_valid,
  output logic [WIDTH-1:0]              read_data,
  output logic                          ready
);
  localparam int LN = lanes(WIDTH, LANE);
  state_t state, state_d;
  logic [DEPTH_LOG2-1:0] cnt, core_wa;
  logic clearing, re;
  logic [LN-1:0] core_we, col_we;
  logic [WIDTH-1:0] core_wd, core_q, col_wd, m1;
  logic [READ_LATENCY-1:0] v;
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= clearing ? cnt + 1'b1 : '0;
    end
  always_comb state_d = state == CLEAR && cnt == '1 ? RUN : state;
  always_comb begin
    clearing = state == CLEAR;
    ready = state == RUN;
  end
  always_comb begin
    re = ready && read_valid;
    core_we = clearing ? '1 : ready ? write_enable : '0;
    core_wa = clearing ? cnt : write_address;
    core_wd = clearing ? '0 : write_data;
  end
  dpmem_core #(.WIDTH(WIDTH), .LANE(LANE), .DEPTH_LOG2(DEPTH_LOG2)) u_core (
    .clock(clock),
    .reset_n(reset_n),
    .write_enable(core_we),
    .write_address(core_wa),
    .write_data(core_wd),
    .read_enable(re),
    .read_address(read_address),
    .read_data(core_q)
  );
  always_ff @(posedge clock)
    if (!reset_n) col_we <= '0;
    else if (re) begin
      col_we <= COLLISION == COLLISION_WRITE_FIRST && read_address == write_address ? write_enable : '0;
      col_wd <= write_data;
    end
  always_comb begin
    m1 = core_q;
    for (int i = 0; i < LN; i++)
      if (col_we[i]) m1[i*LANE +: LANE] = col_wd[i*LANE +: LANE];
  end
  always_ff @(posedge clock)
    if (!reset_n) v <= '0;
    else begin
      v[0] <= re;
      for (int k = 1; k < READ_LATENCY; k++) v[k] <= v[k-1];
    end
  assign read_data_valid = v[READ_LATENCY-1];
  if (READ_LATENCY == 1) begin : g_l1
    assign read_data = m1;
  end else begin : g_ln
    logic [WIDTH-1:0] pd [READ_LATENCY-1];
    always_ff @(posedge clock)
      if (!reset_n) begin
        for (int k = 0; k < READ_LATENCY - 1; k++) pd[k] <= '0;
      end else begin
        if (v[0]) pd[0] <= m1;
        for (int k = 1; k < READ_LATENCY - 1; k++)
          if (v[k]) pd[k] <= pd[k-1];
      end
    assign read_data = pd[READ_LATENCY-2];
  end
endmodule
